// File: rtl/opensync_tx_arb_pkg.sv
// Shared constants for the OpenSync transmit arbiter: state encoding,
// default timing parameters and source indices.
package opensync_tx_arb_pkg;

  localparam int DEF_IFG_CYCLES      = 12;
  localparam int DEF_GRANT_TIMEOUT   = 16;
  localparam int DEF_MAX_FRAME_BYTES = 1536;

  localparam int BYTE_CNT_W = 11;
  localparam int TIMER_W    = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GRANT_WAIT = 3'd1;
  localparam logic [2:0] ST_TRANSMIT   = 3'd2;
  localparam logic [2:0] ST_DRAIN      = 3'd3;
  localparam logic [2:0] ST_IFG        = 3'd4;

  localparam logic SRC_SYNC = 1'b0;
  localparam logic SRC_PKT  = 1'b1;

endpackage

// File: rtl/opensync_tx_arbiter_if.sv
// Source-side request/grant/byte signals and the MAC-side byte stream.
// master = arbiter, slave = frame sources plus MAC.
interface opensync_tx_arbiter_if;
  logic       i_sync_req;
  logic       o_sync_grant;
  logic [7:0] iv_sync_data;
  logic       i_sync_data_wr;
  logic       i_pkt_req;
  logic       o_pkt_grant;
  logic [7:0] iv_pkt_data;
  logic       i_pkt_data_wr;
  logic [7:0] ov_data;
  logic       o_data_wr;
  logic       o_grant_timeout;
  logic       o_oversize;

  modport master (
    input  i_sync_req, iv_sync_data, i_sync_data_wr,
    input  i_pkt_req, iv_pkt_data, i_pkt_data_wr,
    output o_sync_grant, o_pkt_grant, ov_data, o_data_wr,
    output o_grant_timeout, o_oversize
  );

  modport slave (
    output i_sync_req, iv_sync_data, i_sync_data_wr,
    output i_pkt_req, iv_pkt_data, i_pkt_data_wr,
    input  o_sync_grant, o_pkt_grant, ov_data, o_data_wr,
    input  o_grant_timeout, o_oversize
  );
endinterface

// File: rtl/opensync_tx_arb_timer.sv
// Shared up-counter for the grant-wait and IFG phases; holds at terminal count.
module opensync_tx_arb_timer
  import opensync_tx_arb_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] iv_tc,
  output logic         o_tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      count_reg <= '0;
    end else if (i_en && !o_tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign o_tc = (count_reg == iv_tc);

endmodule

// File: rtl/opensync_tx_arbiter.sv
// Frame-atomic two-source arbiter in front of the MAC transmit byte stream.
// Define OPENSYNC_TX_RR_EN for round-robin; otherwise sync has strict priority.
module opensync_tx_arbiter
  import opensync_tx_arb_pkg::*;
#(
  parameter int IFG_CYCLES      = DEF_IFG_CYCLES,
  parameter int GRANT_TIMEOUT   = DEF_GRANT_TIMEOUT,
  parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES
) (
  input  logic i_clk,
  input  logic i_rst,
  opensync_tx_arbiter_if.master bus
);

  localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_FRAME_BYTES);
  localparam logic [TIMER_W-1:0]    IFG_TC  = TIMER_W'(IFG_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    WAIT_TC = TIMER_W'(GRANT_TIMEOUT - 1);

  logic [2:0]            state_reg, state_next;
  logic                  cur_src_reg, cur_src_next;
  logic [BYTE_CNT_W-1:0] byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
  logic [7:0]            data_reg, data_next;
  logic                  data_wr_reg, data_wr_next;
  logic                  sync_grant_reg, sync_grant_next;
  logic                  pkt_grant_reg, pkt_grant_next;
  logic                  timeout_reg, timeout_next;
  logic                  oversize_reg, oversize_next;

  logic                  any_req, sel_src, g_wr;
  logic [7:0]            g_data;
  logic                  timer_load, timer_en, timer_tc;
  logic [TIMER_W-1:0]    timer_tc_val;

  assign any_req = bus.i_sync_req | bus.i_pkt_req;
  assign g_wr    = (cur_src_reg == SRC_SYNC) ? bus.i_sync_data_wr : bus.i_pkt_data_wr;
  assign g_data  = (cur_src_reg == SRC_SYNC) ? bus.iv_sync_data   : bus.iv_pkt_data;
  assign byte_cnt_inc = (byte_cnt_reg == '1) ? byte_cnt_reg : byte_cnt_reg + 1'b1;

`ifdef OPENSYNC_TX_RR_EN
  logic last_src_reg;

  // Resetting to PKT makes the first contested grant go to sync.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_src_reg <= SRC_PKT;
    end else if (state_reg == ST_IDLE && any_req) begin
      last_src_reg <= sel_src;
    end
  end

  always_comb begin
    if (bus.i_sync_req && bus.i_pkt_req) begin
      sel_src = (last_src_reg == SRC_SYNC) ? SRC_PKT : SRC_SYNC;
    end else begin
      sel_src = bus.i_sync_req ? SRC_SYNC : SRC_PKT;
    end
  end
`else
  assign sel_src = bus.i_sync_req ? SRC_SYNC : SRC_PKT;
`endif

  // Grant-wait and IFG never overlap, so one counter serves both.
  assign timer_load   = (state_reg == ST_IDLE) || (state_reg == ST_TRANSMIT) ||
                        (state_reg == ST_DRAIN);
  assign timer_en     = (state_reg == ST_GRANT_WAIT) || (state_reg == ST_IFG);
  assign timer_tc_val = (state_reg == ST_IFG) ? IFG_TC : WAIT_TC;

  opensync_tx_arb_timer #(.W(TIMER_W)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (timer_load),
    .i_en   (timer_en),
    .iv_tc  (timer_tc_val),
    .o_tc   (timer_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      cur_src_reg    <= SRC_SYNC;
      byte_cnt_reg   <= '0;
      data_reg       <= '0;
      data_wr_reg    <= 1'b0;
      sync_grant_reg <= 1'b0;
      pkt_grant_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
      oversize_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_src_reg    <= cur_src_next;
      byte_cnt_reg   <= byte_cnt_next;
      data_reg       <= data_next;
      data_wr_reg    <= data_wr_next;
      sync_grant_reg <= sync_grant_next;
      pkt_grant_reg  <= pkt_grant_next;
      timeout_reg    <= timeout_next;
      oversize_reg   <= oversize_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (any_req) state_next = ST_GRANT_WAIT;
      ST_GRANT_WAIT: begin
        if (g_wr)          state_next = ST_TRANSMIT;
        else if (timer_tc) state_next = ST_IDLE;
      end
      ST_TRANSMIT: begin
        if (!g_wr)                       state_next = ST_IFG;
        else if (byte_cnt_reg == MAX_CNT) state_next = ST_DRAIN;
      end
      ST_DRAIN:      if (!g_wr) state_next = ST_IFG;
      ST_IFG:        if (timer_tc) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_src_next    = cur_src_reg;
    byte_cnt_next   = byte_cnt_reg;
    data_next       = data_reg;
    data_wr_next    = 1'b0;
    sync_grant_next = sync_grant_reg;
    pkt_grant_next  = pkt_grant_reg;
    timeout_next    = 1'b0;
    oversize_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          cur_src_next    = sel_src;
          sync_grant_next = (sel_src == SRC_SYNC);
          pkt_grant_next  = (sel_src == SRC_PKT);
          byte_cnt_next   = '0;
        end
      end
      ST_GRANT_WAIT: begin
        if (g_wr) begin
          data_next     = g_data;
          data_wr_next  = 1'b1;
          byte_cnt_next = byte_cnt_inc;
        end else if (timer_tc) begin
          sync_grant_next = 1'b0;
          pkt_grant_next  = 1'b0;
          timeout_next    = 1'b1;
        end
      end
      ST_TRANSMIT: begin
        if (g_wr && byte_cnt_reg != MAX_CNT) begin
          data_next     = g_data;
          data_wr_next  = 1'b1;
          byte_cnt_next = byte_cnt_inc;
        end else begin
          sync_grant_next = 1'b0;
          pkt_grant_next  = 1'b0;
          oversize_next   = g_wr;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.ov_data         = data_reg;
  assign bus.o_data_wr       = data_wr_reg;
  assign bus.o_sync_grant    = sync_grant_reg;
  assign bus.o_pkt_grant     = pkt_grant_reg;
  assign bus.o_grant_timeout = timeout_reg;
  assign bus.o_oversize      = oversize_reg;

endmodule

// File: tb/tb_opensync_tx_arbiter.sv
// Directed bench for opensync_tx_arbiter: frame-level source model plus a
// byte scoreboard checked every cycle, and hand-computed timing expectations.
module tb_opensync_tx_arbiter;
  import opensync_tx_arb_pkg::*;

  localparam int IFG  = 12;
  localparam int GTO  = 16;
  localparam int MAXB = 1536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  opensync_tx_arbiter_if bus();

  opensync_tx_arbiter #(
    .IFG_CYCLES(IFG), .GRANT_TIMEOUT(GTO), .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  logic       req_d [2];
  logic       wr_d  [2];
  logic [7:0] data_d[2];

  assign bus.i_sync_req     = req_d[0];
  assign bus.i_sync_data_wr = wr_d[0];
  assign bus.iv_sync_data   = data_d[0];
  assign bus.i_pkt_req      = req_d[1];
  assign bus.i_pkt_data_wr  = wr_d[1];
  assign bus.iv_pkt_data    = data_d[1];

  typedef struct { logic [7:0] b; int c; } exp_t;
  exp_t exp_q[$];

  int frames_left[2], len[2], idx[2], fr_no[2], abort_at[2];
  bit active[2], nowr[2], toggle[2];
  int rst_cnt = 3;
  bit abort_fired;

  int cyc, out_bytes, to_cnt, to_cyc, ov_cnt, ov_cyc, gap_run;
  bit seen_byte;
  int gap_q[$];
  int glog[$];
  int rise_cyc[2], fall_cyc[2];
  bit prev_g[2];

  int checks, failures;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] gen(input int s, input int fr, input int i);
    return 8'((i * 7) + (s * 101) + (fr * 13) + 1);
  endfunction

  task automatic send_byte(input int s);
    data_d[s] = gen(s, fr_no[s], idx[s]);
    wr_d[s]   = 1'b1;
    if (idx[s] < MAXB) exp_q.push_back('{b: data_d[s], c: cyc});
    idx[s]++;
  endtask

  task automatic drive_src(input int s);
    logic gnt;
    gnt = (s == 0) ? bus.o_sync_grant : bus.o_pkt_grant;
    if (active[s]) begin
      if (idx[s] == abort_at[s]) begin
        rst = 1'b1; rst_cnt = 1; abort_fired = 1'b1; abort_at[s] = -1;
        active[s] = 1'b0; frames_left[s] = 0; wr_d[s] = 1'b0; req_d[s] = 1'b0;
      end else if (idx[s] < len[s]) begin
        send_byte(s);
      end else begin
        wr_d[s] = 1'b0; active[s] = 1'b0; frames_left[s]--; fr_no[s]++;
        req_d[s] = (frames_left[s] > 0);
      end
    end else if (frames_left[s] > 0 && gnt && req_d[s]) begin
      req_d[s] = 1'b0;
      if (nowr[s]) begin
        frames_left[s] = 0; wr_d[s] = 1'b0;
      end else begin
        active[s] = 1'b1; idx[s] = 0; send_byte(s);
      end
    end else if (toggle[s]) begin
      wr_d[s]   = 1'($urandom_range(0, 1));
      data_d[s] = 8'($urandom_range(0, 255));
    end else begin
      wr_d[s] = 1'b0; data_d[s] = 8'h00;
    end
  endtask

  task automatic monitor();
    logic sg, pg, g;
    exp_t e;
    sg = bus.o_sync_grant;
    pg = bus.o_pkt_grant;
    chk("grant_exclusive", int'(sg & pg), 0);
    for (int s = 0; s < 2; s++) begin
      g = (s == 0) ? sg : pg;
      if (g && !prev_g[s]) begin rise_cyc[s] = cyc; glog.push_back(s); end
      if (!g && prev_g[s]) fall_cyc[s] = cyc;
      prev_g[s] = g;
    end
    if (bus.o_data_wr) begin
      out_bytes++;
      chk("byte_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("byte_data", int'(bus.ov_data), int'(e.b));
        chk("byte_latency", cyc - e.c, 1);
      end
      if (seen_byte && gap_run > 0) gap_q.push_back(gap_run);
      gap_run = 0;
      seen_byte = 1'b1;
    end else begin
      gap_run++;
    end
    if (bus.o_grant_timeout) begin to_cnt++; to_cyc = cyc; end
    if (bus.o_oversize)      begin ov_cnt++; ov_cyc = cyc; end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_cnt > 0) begin rst = 1'b1; rst_cnt--; end
    else rst = 1'b0;
    for (int s = 0; s < 2; s++) drive_src(s);
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int n = 0;
    while ((frames_left[0] > 0 || frames_left[1] > 0 || active[0] || active[1]) && n < limit) begin
      tick(); n++;
    end
    chk(name, int'(n < limit), 1);
    repeat (IFG + 4) tick();
  endtask

  task automatic wait_rise(input int s, input string name, input int limit);
    int n = 0;
    while (!prev_g[s] && n < limit) begin tick(); n++; end
    chk(name, int'(n < limit), 1);
  endtask

  initial begin
    int b0, g0, gq0, to0, ov0, rc, g;
    int exp_ord[4];
    for (int s = 0; s < 2; s++) begin
      req_d[s] = 1'b0; wr_d[s] = 1'b0; data_d[s] = 8'h00; abort_at[s] = -1;
    end

    // reset values
    repeat (4) tick();
    chk("rst_data_wr", int'(bus.o_data_wr), 0);
    chk("rst_ov_data", int'(bus.ov_data), 0);
    chk("rst_sync_grant", int'(bus.o_sync_grant), 0);
    chk("rst_pkt_grant", int'(bus.o_pkt_grant), 0);
    chk("rst_timeout", int'(bus.o_grant_timeout), 0);
    chk("rst_oversize", int'(bus.o_oversize), 0);
    $display("txn reset checks=%0d", checks);
    repeat (3) tick();

    // single 64-byte sync frame
    b0 = out_bytes; rc = cyc;
    frames_left[0] = 1; len[0] = 64; req_d[0] = 1'b1;
    wait_rise(0, "t1_wait_grant", 20);
    chk("t1_grant_latency", rise_cyc[0] - rc, 1);
    wait_quiet("t1_done", 200);
    chk("t1_bytes", out_bytes - b0, 64);
    chk("t1_grant_fall", fall_cyc[0] - rise_cyc[0], 65);
    $display("txn sync_frame len=64 bytes_out=%0d", out_bytes - b0);

    // both sources requesting continuously, 60-byte frames
    b0 = out_bytes; g0 = glog.size(); gq0 = gap_q.size();
`ifdef OPENSYNC_TX_RR_EN
    exp_ord = '{1, 0, 1, 0};
`else
    exp_ord = '{0, 0, 1, 1};
`endif
    frames_left[0] = 2; len[0] = 60; req_d[0] = 1'b1;
    frames_left[1] = 2; len[1] = 60; req_d[1] = 1'b1;
    wait_quiet("t2_done", 2000);
    chk("t2_bytes", out_bytes - b0, 240);
    chk("t2_grant_count", glog.size() - g0, 4);
    for (int i = 0; i < 4; i++)
      if (g0 + i < glog.size()) chk("t2_grant_order", glog[g0 + i], exp_ord[i]);
    chk("t2_gap_count", gap_q.size() - gq0, 4);
    for (int i = 1; i < 4; i++)
      if (gq0 + i < gap_q.size()) chk("t2_ifg_gap", gap_q[gq0 + i], 14);
    $display("txn contention frames=4 bytes_out=%0d", out_bytes - b0);

    // pkt granted but never streams; sync pending
    to0 = to_cnt; ov0 = ov_cnt; b0 = out_bytes;
    nowr[1] = 1'b1; frames_left[1] = 1; len[1] = 1; req_d[1] = 1'b1;
    wait_rise(1, "t3_wait_pkt_grant", 20);
    frames_left[0] = 1; len[0] = 10; req_d[0] = 1'b1;
    wait_quiet("t3_done", 200);
    nowr[1] = 1'b0;
    chk("t3_grant_len", fall_cyc[1] - rise_cyc[1], 16);
    chk("t3_timeout_pulses", to_cnt - to0, 1);
    chk("t3_timeout_cycle", to_cyc, fall_cyc[1]);
    chk("t3_sync_next", rise_cyc[0] - fall_cyc[1], 1);
    chk("t3_bytes", out_bytes - b0, 10);
    chk("t3_no_oversize", ov_cnt - ov0, 0);
    $display("txn grant_timeout pulses=%0d", to_cnt - to0);

    // oversize sync frame, pkt waiting behind it
    b0 = out_bytes; ov0 = ov_cnt;
    frames_left[0] = 1; len[0] = 2000; req_d[0] = 1'b1;
    wait_rise(0, "t4_wait_grant", 20);
    g = rise_cyc[0];
    frames_left[1] = 1; len[1] = 8; req_d[1] = 1'b1;
    wait_quiet("t4_done", 3000);
    chk("t4_bytes", out_bytes - b0, 1536 + 8);
    chk("t4_oversize_pulses", ov_cnt - ov0, 1);
    chk("t4_oversize_cycle", ov_cyc - g, 1537);
    chk("t4_grant_fall", fall_cyc[0] - g, 1537);
    chk("t4_pkt_grant_after_drain", rise_cyc[1] - g, 2014);
    $display("txn oversize len=2000 bytes_out=%0d", out_bytes - b0);

    // reset at byte 30 of a pkt frame, then a fresh request
    b0 = out_bytes; to0 = to_cnt; ov0 = ov_cnt;
    frames_left[1] = 1; len[1] = 100; abort_at[1] = 30; req_d[1] = 1'b1;
    for (int n = 0; n < 200 && !abort_fired; n++) tick();
    chk("t5_reset_fired", int'(abort_fired), 1);
    tick();
    chk("t5_data_wr", int'(bus.o_data_wr), 0);
    chk("t5_sync_grant", int'(bus.o_sync_grant), 0);
    chk("t5_pkt_grant", int'(bus.o_pkt_grant), 0);
    chk("t5_bytes_before_reset", out_bytes - b0, 30);
    chk("t5_grant_fall", fall_cyc[1] - rise_cyc[1], 31);
    repeat (4) tick();
    abort_fired = 1'b0;
    chk("t5_no_pulses", (to_cnt - to0) + (ov_cnt - ov0), 0);
    b0 = out_bytes; rc = cyc;
    frames_left[0] = 1; len[0] = 16; req_d[0] = 1'b1;
    wait_rise(0, "t5_wait_grant", 20);
    chk("t5_grant_latency", rise_cyc[0] - rc, 1);
    wait_quiet("t5_done", 200);
    chk("t5_bytes_after", out_bytes - b0, 16);
    $display("txn reset_mid_frame bytes_after=%0d", out_bytes - b0);

    // ungranted pkt source toggles wr during a sync frame
    b0 = out_bytes; g0 = glog.size();
    toggle[1] = 1'b1;
    frames_left[0] = 1; len[0] = 40; req_d[0] = 1'b1;
    wait_rise(0, "t6_wait_grant", 20);
    wait_quiet("t6_done", 200);
    toggle[1] = 1'b0;
    repeat (2) tick();
    chk("t6_bytes", out_bytes - b0, 40);
    chk("t6_grant_count", glog.size() - g0, 1);
    $display("txn ungranted_toggle bytes_out=%0d", out_bytes - b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
